// File: rtl/det_pkg.sv
// Shared constants and state encoding for the detection window counter.
package det_pkg;

  localparam int CNT_W_DEF = 8;

  // All-ones value of a default-width count; the running count saturates here.
  localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector: a det level held high produces a single one-cycle rise pulse.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic det_i,
  output logic rise_o
);

  logic det_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) det_q <= 1'b0;
    else      det_q <= det_i;
  end

  assign rise_o = det_i & ~det_q;

endmodule

// File: rtl/det_window_counter.sv
// Counts detector rising edges over back-to-back windows and hands each result out
// through a valid/ready register. Define DWC_ALARM_EN to enable the threshold alarm pulse.
module det_window_counter
  import det_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             det,
  input  logic [CNT_W-1:0] win_len,
  input  logic [CNT_W-1:0] thr,
  input  logic             cnt_ready,
  output logic [CNT_W-1:0] cnt_o,
  output logic             cnt_valid,
  output logic             ovr,
  output logic             alarm
);

  localparam logic [CNT_W-1:0] SatMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] One    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] runCount_q, runCount_d;
  logic [CNT_W-1:0] cntOut_q, cntOut_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic             rise;
  logic [CNT_W-1:0] winLenEff;
  logic [CNT_W-1:0] countInc;
  logic             capture;
  logic             clearOvr;
  logic             transfer;
  logic             accept;

  edge_det u_edge_det (
    .clk    (clk),
    .rst    (rst),
    .det_i  (det),
    .rise_o (rise)
  );

  assign winLenEff = (win_len == '0) ? One : win_len;
  assign countInc  = (rise && (runCount_q != SatMax)) ? runCount_q + One : runCount_q;

  // Window sequencing: the last cycle of a window captures and reloads in the same edge.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    runCount_d  = runCount_q;
    capture     = 1'b0;
    clearOvr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d     = RUN;
          remaining_d = winLenEff;
          runCount_d  = '0;
          clearOvr    = 1'b1;
        end
      end
      RUN: begin
        if (!en) begin
          state_d     = IDLE;
          remaining_d = '0;
          runCount_d  = '0;
        end else if (remaining_q == One) begin
          capture     = 1'b1;
          remaining_d = winLenEff;
          runCount_d  = '0;
        end else begin
          remaining_d = remaining_q - One;
          runCount_d  = countInc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign transfer = valid_q & cnt_ready;
  assign accept   = capture & (~valid_q | transfer);

  always_comb begin
    cntOut_d = cntOut_q;
    valid_d  = transfer ? 1'b0 : valid_q;
    ovr_d    = clearOvr ? 1'b0 : ovr_q;
    if (accept) begin
      cntOut_d = countInc;
      valid_d  = 1'b1;
    end else if (capture) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      runCount_q  <= '0;
      cntOut_q    <= '0;
      valid_q     <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      runCount_q  <= runCount_d;
      cntOut_q    <= cntOut_d;
      valid_q     <= valid_d;
      ovr_q       <= ovr_d;
    end
  end

  assign cnt_o     = cntOut_q;
  assign cnt_valid = valid_q;
  assign ovr       = ovr_q;

`ifdef DWC_ALARM_EN
  // Only results that actually land in cnt_o can raise the alarm.
  logic alarm_q, alarm_d;

  assign alarm_d = accept && (thr != '0) && (countInc >= thr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) alarm_q <= 1'b0;
    else      alarm_q <= alarm_d;
  end

  assign alarm = alarm_q;
`else
  logic unusedThr;
  assign unusedThr = ^thr;
  assign alarm     = 1'b0;
`endif

endmodule

// File: tb/tb_det_window_counter.sv
// Directed self-checking bench for det_window_counter with hand-computed expectations.
module tb_det_window_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       det;
  logic [7:0] win_len;
  logic [7:0] thr;
  logic       cnt_ready;
  logic [7:0] cnt_o;
  logic       cnt_valid;
  logic       ovr;
  logic       alarm;

  int checkCount = 0;
  int passCount  = 0;

  det_window_counter dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .det       (det),
    .win_len   (win_len),
    .thr       (thr),
    .cnt_ready (cnt_ready),
    .cnt_o     (cnt_o),
    .cnt_valid (cnt_valid),
    .ovr       (ovr),
    .alarm     (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; det = 1'b0; win_len = 8'd0; thr = 8'd0; cnt_ready = 1'b0;
    tick(); tick();
    checkCount++;
    if (cnt_o !== 8'd0) $display("[TB] FAIL reset_cnt_o: got %0d expected 0", cnt_o);
    else passCount++;
    checkCount++;
    if (cnt_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", cnt_valid);
    else passCount++;
    checkCount++;
    if (ovr !== 1'b0) $display("[TB] FAIL reset_ovr: got %b expected 0", ovr);
    else passCount++;
    checkCount++;
    if (alarm !== 1'b0) $display("[TB] FAIL reset_alarm: got %b expected 0", alarm);
    else passCount++;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic_window();
    en = 1'b1; win_len = 8'd4;
    tick();
    det = 1'b1; tick();
    det = 1'b0; tick();
    det = 1'b1; tick();
    checkCount++;
    if (cnt_valid !== 1'b0) $display("[TB] FAIL basic_early_valid: got %b expected 0", cnt_valid);
    else passCount++;
    det = 1'b0; tick();
    checkCount++;
    if (cnt_valid !== 1'b1) $display("[TB] FAIL basic_valid: got %b expected 1", cnt_valid);
    else passCount++;
    checkCount++;
    if (cnt_o !== 8'd2) $display("[TB] FAIL basic_cnt: got %0d expected 2", cnt_o);
    else passCount++;
    en = 1'b0; cnt_ready = 1'b1;
    tick();
    cnt_ready = 1'b0;
    checkCount++;
    if (cnt_valid !== 1'b0) $display("[TB] FAIL basic_transfer: got %b expected 0", cnt_valid);
    else passCount++;
  endtask

  task automatic test_held_level();
    en = 1'b1; win_len = 8'd8;
    tick();
    for (int c = 1; c <= 8; c++) begin
      det = (c >= 2 && c <= 6);
      tick();
    end
    checkCount++;
    if (cnt_valid !== 1'b1) $display("[TB] FAIL held_valid: got %b expected 1", cnt_valid);
    else passCount++;
    checkCount++;
    if (cnt_o !== 8'd1) $display("[TB] FAIL held_cnt: got %0d expected 1", cnt_o);
    else passCount++;
    en = 1'b0; cnt_ready = 1'b1;
    tick();
    cnt_ready = 1'b0;
  endtask

  task automatic test_overflow();
    cnt_ready = 1'b0; en = 1'b1; win_len = 8'd2;
    tick();
    det = 1'b1; tick();
    det = 1'b0; tick();
    checkCount++;
    if (cnt_o !== 8'd1 || cnt_valid !== 1'b1)
      $display("[TB] FAIL ovf_first: got cnt=%0d valid=%b expected cnt=1 valid=1", cnt_o, cnt_valid);
    else passCount++;
    tick(); tick();
    checkCount++;
    if (cnt_o !== 8'd1) $display("[TB] FAIL ovf_hold_cnt: got %0d expected 1", cnt_o);
    else passCount++;
    checkCount++;
    if (ovr !== 1'b1) $display("[TB] FAIL ovf_sticky: got %b expected 1", ovr);
    else passCount++;
    en = 1'b0; cnt_ready = 1'b1;
    tick();
    cnt_ready = 1'b0;
    tick();
    checkCount++;
    if (cnt_valid !== 1'b0) $display("[TB] FAIL ovf_single_transfer: got %b expected 0", cnt_valid);
    else passCount++;
    checkCount++;
    if (ovr !== 1'b1) $display("[TB] FAIL ovf_after_transfer: got %b expected 1", ovr);
    else passCount++;
  endtask

  task automatic test_coincident();
    en = 1'b1; win_len = 8'd2;
    tick();
    checkCount++;
    if (ovr !== 1'b0) $display("[TB] FAIL coin_ovr_clear: got %b expected 0", ovr);
    else passCount++;
    det = 1'b1; tick();
    det = 1'b0; tick();
    tick();
    checkCount++;
    if (cnt_o !== 8'd1 || cnt_valid !== 1'b1)
      $display("[TB] FAIL coin_stable: got cnt=%0d valid=%b expected cnt=1 valid=1", cnt_o, cnt_valid);
    else passCount++;
    cnt_ready = 1'b1;
    tick();
    checkCount++;
    if (cnt_o !== 8'd0) $display("[TB] FAIL coin_cnt: got %0d expected 0", cnt_o);
    else passCount++;
    checkCount++;
    if (cnt_valid !== 1'b1) $display("[TB] FAIL coin_valid: got %b expected 1", cnt_valid);
    else passCount++;
    checkCount++;
    if (ovr !== 1'b0) $display("[TB] FAIL coin_ovr: got %b expected 0", ovr);
    else passCount++;
    en = 1'b0;
    tick();
    cnt_ready = 1'b0;
    checkCount++;
    if (cnt_valid !== 1'b0) $display("[TB] FAIL coin_drain: got %b expected 0", cnt_valid);
    else passCount++;
  endtask

  task automatic test_en_drop();
    logic sawValid;
    cnt_ready = 1'b0; en = 1'b1; win_len = 8'd0; det = 1'b0;
    tick();
    tick();
    checkCount++;
    if (cnt_valid !== 1'b1 || cnt_o !== 8'd0)
      $display("[TB] FAIL len0_capture: got valid=%b cnt=%0d expected valid=1 cnt=0", cnt_valid, cnt_o);
    else passCount++;
    tick();
    checkCount++;
    if (ovr !== 1'b1) $display("[TB] FAIL len0_ovr: got %b expected 1", ovr);
    else passCount++;
    en = 1'b0;
    tick();
    cnt_ready = 1'b1;
    tick();
    cnt_ready = 1'b0;
    checkCount++;
    if (cnt_valid !== 1'b0 || ovr !== 1'b1)
      $display("[TB] FAIL drop_pre: got valid=%b ovr=%b expected valid=0 ovr=1", cnt_valid, ovr);
    else passCount++;
    en = 1'b1; win_len = 8'd10;
    tick();
    checkCount++;
    if (ovr !== 1'b0) $display("[TB] FAIL reenable_ovr: got %b expected 0", ovr);
    else passCount++;
    det = 1'b1; tick();
    det = 1'b0; tick();
    det = 1'b1; tick();
    en = 1'b0; det = 1'b0;
    sawValid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (cnt_valid === 1'b1) sawValid = 1'b1;
    end
    checkCount++;
    if (sawValid !== 1'b0) $display("[TB] FAIL drop_no_capture: got valid seen=%b expected 0", sawValid);
    else passCount++;
  endtask

  task automatic test_reset_mid();
    cnt_ready = 1'b0; en = 1'b1; win_len = 8'd2;
    tick();
    det = 1'b1; tick();
    det = 1'b0; tick();
    checkCount++;
    if (cnt_valid !== 1'b1) $display("[TB] FAIL rstmid_pre: got %b expected 1", cnt_valid);
    else passCount++;
    det = 1'b1; tick();
    #2 rst = 1'b0;
    #1;
    checkCount++;
    if (cnt_valid !== 1'b0 || cnt_o !== 8'd0)
      $display("[TB] FAIL rstmid_async: got valid=%b cnt=%0d expected valid=0 cnt=0", cnt_valid, cnt_o);
    else passCount++;
    en = 1'b0; det = 1'b0;
    tick();
    rst = 1'b1;
    tick(); tick();
    checkCount++;
    if (cnt_valid !== 1'b0) $display("[TB] FAIL rstmid_after: got %b expected 0", cnt_valid);
    else passCount++;
  endtask

  task automatic test_alarm();
    logic expAlarm;
`ifdef DWC_ALARM_EN
    expAlarm = 1'b1;
`else
    expAlarm = 1'b0;
`endif
    thr = 8'd3; cnt_ready = 1'b0; en = 1'b1; win_len = 8'd6;
    tick();
    for (int c = 1; c <= 6; c++) begin
      det = (c % 2 == 1);
      tick();
    end
    checkCount++;
    if (cnt_o !== 8'd3 || cnt_valid !== 1'b1)
      $display("[TB] FAIL alarm_win1: got cnt=%0d valid=%b expected cnt=3 valid=1", cnt_o, cnt_valid);
    else passCount++;
    checkCount++;
    if (alarm !== expAlarm) $display("[TB] FAIL alarm_pulse: got %b expected %b", alarm, expAlarm);
    else passCount++;
    cnt_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      det = (c == 1 || c == 3);
      tick();
      if (c == 1) begin
        cnt_ready = 1'b0;
        checkCount++;
        if (alarm !== 1'b0) $display("[TB] FAIL alarm_one_cycle: got %b expected 0", alarm);
        else passCount++;
      end
    end
    checkCount++;
    if (cnt_o !== 8'd2 || cnt_valid !== 1'b1)
      $display("[TB] FAIL alarm_win2: got cnt=%0d valid=%b expected cnt=2 valid=1", cnt_o, cnt_valid);
    else passCount++;
    checkCount++;
    if (alarm !== 1'b0) $display("[TB] FAIL alarm_below_thr: got %b expected 0", alarm);
    else passCount++;
    en = 1'b0; det = 1'b0; cnt_ready = 1'b1;
    tick();
    cnt_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_window();
    test_held_level();
    test_overflow();
    test_coincident();
    test_en_drop();
    test_reset_mid();
    test_alarm();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/det_window_counter.md
DET_WINDOW_COUNTER -- requirements
Module: det_window_counter

Interface
REQ-001 Parameter CNT_W, 8, width of event count, window length and threshold.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-004 en  input  1  1 = run counting windows; 0 = idle.
REQ-005 det  input  1  detection flag from the upstream "10" sequence detector (its z output).
REQ-006 win_len  input  CNT_W  window length in clock cycles; sampled at each window start.
REQ-007 thr  input  CNT_W  alarm threshold; used only when DWC_ALARM_EN is defined.
REQ-008 cnt_ready  input  1  consumer accepts cnt_o this cycle.
REQ-009 cnt_o  output  CNT_W  event count of the last completed window.
REQ-010 cnt_valid  output  1  cnt_o holds an unaccepted result.
REQ-011 ovr  output  1  sticky: a completed window was dropped.
REQ-012 alarm  output  1  one-cycle pulse, threshold reached.

Function
REQ-013 Event = det & ~det_q, where det_q is det registered each cycle; a det level held high across several cycles SHALL count once.
REQ-014 FSM states: IDLE, RUN; IDLE->RUN when en=1; RUN->IDLE when en=0; no other states.
REQ-015 On IDLE->RUN and on every window end, the remaining-cycle counter SHALL load win_len; win_len=0 SHALL be treated as 1.
REQ-016 In RUN, each cycle decrements remaining; an event in a window cycle increments the running count, saturating at 2^CNT_W-1.
REQ-017 Window end = RUN cycle with remaining==1; the count including that cycle's event SHALL be captured into cnt_o at that edge; cnt_valid visible the next cycle.
REQ-018 Windows SHALL be back-to-back: running count restarts at 0 the cycle after capture, no gap cycle.
REQ-019 Transfer occurs when cnt_valid & cnt_ready; cnt_valid then clears next cycle unless a new capture occurs in the same cycle.
REQ-020 Capture with cnt_valid=1 and cnt_ready=0: cnt_o and cnt_valid unchanged, new result dropped, ovr set.
REQ-021 Capture coincident with transfer: new value loaded, cnt_valid stays 1, ovr unchanged.
REQ-022 cnt_o SHALL be stable while cnt_valid=1 and no transfer.
REQ-023 en=0 mid-window: partial count discarded, FSM to IDLE next cycle; pending cnt_valid/cnt_o retained until accepted.
REQ-024 ovr SHALL clear only on reset or on the IDLE->RUN transition.

Reset
REQ-025 rst=0 asynchronously forces: state IDLE, det_q=0, running count=0, remaining=0, cnt_o=0, cnt_valid=0, ovr=0, alarm=0.
REQ-026 Reset release SHALL take effect on the first posedge with rst=1; reset mid-window discards all results.

Configuration
REQ-027 Macro DWC_ALARM_EN: defined -> alarm pulses for one cycle, aligned with cnt_valid rise, for each captured (not dropped) count with thr!=0 and count>=thr.
REQ-028 DWC_ALARM_EN undefined -> alarm tied 0, thr ignored, no compare logic synthesized.

Structure
REQ-029 Package det_pkg SHALL hold CNT_W default, the state encoding constants (IDLE, RUN), and the saturation max constant.
REQ-030 Sub-module edge_det (det in, det_q register, rise pulse out, same clk/rst) SHALL implement REQ-013.

Verification
REQ-031 Reset then en=1, win_len=4, det pulses (1 cycle each) in window cycles 1 and 3 -> cnt_o=2, cnt_valid=1 one cycle after window end.
REQ-032 det held high 5 cycles inside one window of 8 -> cnt_o=1.
REQ-033 cnt_ready=0, win_len=2, two windows complete -> cnt_o=first count, ovr=1; cnt_ready=1 then transfers first count only.
REQ-034 cnt_ready=1 at the exact capture edge of window 2 while window 1 is valid -> cnt_o=window-2 count, cnt_valid stays 1, ovr=0.
REQ-035 en dropped after 3 of win_len=10 cycles with 2 events -> no capture, FSM IDLE; re-enable clears ovr.
REQ-036 DWC_ALARM_EN defined, thr=3, window with 3 events -> alarm=1 for one cycle with cnt_valid rise; with 2 events alarm stays 0.
